// File: rtl/ntt_sched_pkg.sv
// Shared types and sizing for the NTT dispatch arbiter.
// Slot states, bank count, start timeout and stall counter width.
package ntt_sched_pkg;

  localparam int NUM_BANKS     = 4;
  localparam int START_TIMEOUT = 16;
  localparam int STALL_W       = 8;
  localparam int TO_W          = $clog2(START_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_WAIT = 2'd2,
    S_RUN  = 2'd3
  } slot_state_e;

endpackage

// File: rtl/ntt_core_slot.sv
// One per-core job slot: request latch, launch FSM,
// busy watchdog and sticky timeout flag.
module ntt_core_slot
  import ntt_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  input  logic [NUM_BANKS-1:0] req_mask_i,
  input  logic                 busy_i,
  input  logic                 grant_i,
  output logic                 req_ready_o,
  output logic                 pend_o,
  output logic [NUM_BANKS-1:0] mask_o,
  output logic                 start_o,
  output logic                 release_o,
  output logic                 timeout_err_o
);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(START_TIMEOUT - 1);

  slot_state_e          state_q, state_d;
  logic [NUM_BANKS-1:0] mask_q, mask_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic                 start_q, start_d;
  logic                 err_q, err_d;

  assign req_ready_o   = (state_q == S_IDLE);
  assign pend_o        = (state_q == S_PEND);
  assign mask_o        = mask_q;
  assign start_o       = start_q;
  assign timeout_err_o = err_q;

  // Next state: accept, launch, wait for busy, run to completion.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    err_d     = err_q;
    release_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_PEND;
          mask_d  = req_mask_i;
        end
      end
      S_PEND: begin
        if (grant_i) begin
          state_d = S_WAIT;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (busy_i) begin
          state_d = S_RUN;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_IDLE;
          err_d     = 1'b1;
          release_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!busy_i) begin
          state_d   = S_IDLE;
          release_o = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/ntt_dispatch_arbiter.sv
// Two-core NTT job dispatcher: bank-conflict aware
// launch arbitration with round-robin tie break.
module ntt_dispatch_arbiter
  import ntt_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid_0,
  input  logic         req_valid_1,
  output logic         req_ready_0,
  output logic         req_ready_1,
  input  logic [3:0]   req_bank_mask_0,
  input  logic [3:0]   req_bank_mask_1,
  input  logic         busy_0,
  input  logic         busy_1,
  output logic         start_0,
  output logic         start_1,
  output logic [3:0]   owned_mask,
  output logic [7:0]   stall_cnt,
  output logic         timeout_err_0,
  output logic         timeout_err_1
);

  logic                 pend_0, pend_1;
  logic                 rel_0, rel_1;
  logic                 gnt_0, gnt_1;
  logic                 elig_0, elig_1;
  logic                 clash;
  logic [NUM_BANKS-1:0] mask_0, mask_1;
  logic [NUM_BANKS-1:0] owned_q, owned_d;
  logic                 rr_q, rr_d;
  logic [STALL_W-1:0]   stall_q, stall_d;

  ntt_core_slot u_slot_0 (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_0),
    .req_mask_i    (req_bank_mask_0),
    .busy_i        (busy_0),
    .grant_i       (gnt_0),
    .req_ready_o   (req_ready_0),
    .pend_o        (pend_0),
    .mask_o        (mask_0),
    .start_o       (start_0),
    .release_o     (rel_0),
    .timeout_err_o (timeout_err_0)
  );

  ntt_core_slot u_slot_1 (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_1),
    .req_mask_i    (req_bank_mask_1),
    .busy_i        (busy_1),
    .grant_i       (gnt_1),
    .req_ready_o   (req_ready_1),
    .pend_o        (pend_1),
    .mask_o        (mask_1),
    .start_o       (start_1),
    .release_o     (rel_1),
    .timeout_err_o (timeout_err_1)
  );

  assign owned_mask = owned_q;
  assign stall_cnt  = stall_q;

  // Eligibility uses the registered owned set, so a
  // release only frees banks from the following cycle.
  assign elig_0 = pend_0 && ((mask_0 & owned_q) == '0);
  assign elig_1 = pend_1 && ((mask_1 & owned_q) == '0);
  assign clash  = (mask_0 & mask_1) != '0;

  // Grant selection; rr pointer moves only on contention.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    rr_d  = rr_q;
    if (elig_0 && elig_1 && clash) begin
      gnt_0 = !rr_q;
      gnt_1 = rr_q;
      rr_d  = !rr_q;
    end else begin
      gnt_0 = elig_0;
      gnt_1 = elig_1;
    end
  end

  // Bank ownership update and saturating stall count.
  always_comb begin
    owned_d = owned_q;
    if (rel_0) owned_d = owned_d & ~mask_0;
    if (rel_1) owned_d = owned_d & ~mask_1;
    if (gnt_0) owned_d = owned_d | mask_0;
    if (gnt_1) owned_d = owned_d | mask_1;
    stall_d = stall_q;
    if (((pend_0 && !gnt_0) || (pend_1 && !gnt_1))
        && (stall_q != {STALL_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  // Arbiter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      owned_q <= '0;
      rr_q    <= 1'b0;
      stall_q <= '0;
    end else begin
      owned_q <= owned_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_ntt_dispatch_arbiter.sv
// Directed bench for ntt_dispatch_arbiter: a cycle table
// plus hand sequences for collision, timeout, stall, reset.
module tb_ntt_dispatch_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid_0, req_valid_1;
  logic       req_ready_0, req_ready_1;
  logic [3:0] req_bank_mask_0, req_bank_mask_1;
  logic       busy_0, busy_1;
  logic       start_0, start_1;
  logic [3:0] owned_mask;
  logic [7:0] stall_cnt;
  logic       timeout_err_0, timeout_err_1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ntt_dispatch_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_0     (req_valid_0),
    .req_valid_1     (req_valid_1),
    .req_ready_0     (req_ready_0),
    .req_ready_1     (req_ready_1),
    .req_bank_mask_0 (req_bank_mask_0),
    .req_bank_mask_1 (req_bank_mask_1),
    .busy_0          (busy_0),
    .busy_1          (busy_1),
    .start_0         (start_0),
    .start_1         (start_1),
    .owned_mask      (owned_mask),
    .stall_cnt       (stall_cnt),
    .timeout_err_0   (timeout_err_0),
    .timeout_err_1   (timeout_err_1)
  );

  typedef struct {
    logic       v0, v1;
    logic [3:0] m0, m1;
    logic       b0, b1;
    logic       r0, r1, s0, s1;
    logic [3:0] own;
    logic [7:0] st;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(
    input logic v0, v1,
    input logic [3:0] m0, m1,
    input logic b0, b1,
    input logic r0, r1, s0, s1,
    input logic [3:0] own,
    input logic [7:0] st);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.m0 = m0; v.m1 = m1;
    v.b0 = b0; v.b1 = b1; v.r0 = r0; v.r1 = r1;
    v.s0 = s0; v.s1 = s1; v.own = own; v.st = st;
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv(
    input logic v0, v1,
    input logic [3:0] m0, m1,
    input logic b0, b1);
    req_valid_0     = v0;
    req_valid_1     = v1;
    req_bank_mask_0 = m0;
    req_bank_mask_1 = m1;
    busy_0          = b0;
    busy_1          = b1;
  endtask

  // order: rdy0 rdy1 st0 st1 owned err0 err1 stall
  task automatic chk(
    input string nm,
    input logic r0, r1, s0, s1,
    input logic [3:0] own,
    input logic e0, e1,
    input logic [7:0] st);
    logic [17:0] act, exp;
    act = {req_ready_0, req_ready_1, start_0, start_1,
           owned_mask, timeout_err_0, timeout_err_1,
           stall_cnt};
    exp = {r0, r1, s0, s1, own, e0, e1, st};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got r%b%b s%b%b own=%b e%b%b stall=%0d, want r%b%b s%b%b own=%b e%b%b stall=%0d",
        nm, act[17], act[16], act[15], act[14], act[13:10],
        act[9], act[8], act[7:0],
        r0, r1, s0, s1, own, e0, e1, st);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(0, 0, 4'h0, 4'h0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic collide(input string nm);
    do_reset();
    chk({nm, "_c0"}, 1, 1, 0, 0, 4'h0, 0, 0, 8'd0);
    drv(1, 1, 4'b0010, 4'b0010, 0, 0);
    tick();
    chk({nm, "_c1"}, 0, 0, 0, 0, 4'h0, 0, 0, 8'd0);
    drv(0, 0, 4'h0, 4'h0, 0, 0);
    tick();
    chk({nm, "_c2"}, 0, 0, 1, 0, 4'b0010, 0, 0, 8'd1);
  endtask

  initial begin
    drv(0, 0, 4'h0, 4'h0, 0, 0);
    // disjoint dual launch, staggered release, zero-mask launch
    tbl[0]  = mk(1,1,4'b0011,4'b1100,0,0, 1,1,0,0,4'b0000,8'd0);
    tbl[1]  = mk(0,0,4'b0000,4'b0000,0,0, 0,0,0,0,4'b0000,8'd0);
    tbl[2]  = mk(0,0,4'b0000,4'b0000,1,1, 0,0,1,1,4'b1111,8'd0);
    tbl[3]  = mk(0,0,4'b0000,4'b0000,1,1, 0,0,0,0,4'b1111,8'd0);
    tbl[4]  = mk(0,0,4'b0000,4'b0000,0,1, 0,0,0,0,4'b1111,8'd0);
    tbl[5]  = mk(0,0,4'b0000,4'b0000,0,0, 1,0,0,0,4'b1100,8'd0);
    tbl[6]  = mk(0,0,4'b0000,4'b0000,0,0, 1,1,0,0,4'b0000,8'd0);
    tbl[7]  = mk(1,0,4'b1111,4'b0000,0,0, 1,1,0,0,4'b0000,8'd0);
    tbl[8]  = mk(0,0,4'b0000,4'b0000,0,0, 0,1,0,0,4'b0000,8'd0);
    tbl[9]  = mk(0,1,4'b0000,4'b0000,1,0, 0,1,1,0,4'b1111,8'd0);
    tbl[10] = mk(0,0,4'b0000,4'b0000,1,0, 0,0,0,0,4'b1111,8'd0);
    tbl[11] = mk(0,0,4'b0000,4'b0000,1,1, 0,0,0,1,4'b1111,8'd0);
    tbl[12] = mk(0,0,4'b0000,4'b0000,0,0, 0,0,0,0,4'b1111,8'd0);
    tbl[13] = mk(0,0,4'b0000,4'b0000,0,0, 1,1,0,0,4'b0000,8'd0);

    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("tbl%0d", i), tbl[i].r0, tbl[i].r1,
          tbl[i].s0, tbl[i].s1, tbl[i].own, 0, 0, tbl[i].st);
      drv(tbl[i].v0, tbl[i].v1, tbl[i].m0, tbl[i].m1,
          tbl[i].b0, tbl[i].b1);
      tick();
    end

    // same-mask collision, then round-robin flips
    do_reset();
    chk("col_c0", 1, 1, 0, 0, 4'h0, 0, 0, 8'd0);
    drv(1, 1, 4'b0001, 4'b0001, 0, 0); tick();
    chk("col_c1", 0, 0, 0, 0, 4'h0, 0, 0, 8'd0);
    drv(0, 0, 4'h0, 4'h0, 0, 0); tick();
    chk("col_c2", 0, 0, 1, 0, 4'b0001, 0, 0, 8'd1);
    drv(0, 0, 4'h0, 4'h0, 1, 0); tick();
    chk("col_c3", 0, 0, 0, 0, 4'b0001, 0, 0, 8'd2);
    drv(0, 0, 4'h0, 4'h0, 1, 0); tick();
    chk("col_c4", 0, 0, 0, 0, 4'b0001, 0, 0, 8'd3);
    drv(0, 0, 4'h0, 4'h0, 0, 0); tick();
    chk("col_c5", 1, 0, 0, 0, 4'b0000, 0, 0, 8'd4);
    drv(0, 0, 4'h0, 4'h0, 0, 0); tick();
    chk("col_c6", 1, 0, 0, 1, 4'b0001, 0, 0, 8'd4);
    drv(0, 0, 4'h0, 4'h0, 0, 1); tick();
    chk("col_c7", 1, 0, 0, 0, 4'b0001, 0, 0, 8'd4);
    drv(0, 0, 4'h0, 4'h0, 0, 0); tick();
    chk("col_c8", 1, 1, 0, 0, 4'b0000, 0, 0, 8'd4);
    drv(1, 1, 4'b0001, 4'b0001, 0, 0); tick();
    chk("col_c9", 0, 0, 0, 0, 4'b0000, 0, 0, 8'd4);
    drv(0, 0, 4'h0, 4'h0, 0, 0); tick();
    chk("col_c10", 0, 0, 0, 1, 4'b0001, 0, 0, 8'd5);

    // rr pointer returns to core 0 on reset
    collide("rr_a");
    collide("rr_b");

    // start timeout: busy never seen
    do_reset();
    chk("to_c0", 1, 1, 0, 0, 4'h0, 0, 0, 8'd0);
    drv(1, 0, 4'b0001, 4'h0, 0, 0); tick();
    chk("to_c1", 0, 1, 0, 0, 4'h0, 0, 0, 8'd0);
    drv(0, 0, 4'h0, 4'h0, 0, 0); tick();
    chk("to_c2", 0, 1, 1, 0, 4'b0001, 0, 0, 8'd0);
    tick();
    for (int c = 3; c <= 17; c++) begin
      chk($sformatf("to_c%0d", c), 0, 1, 0, 0,
          4'b0001, 0, 0, 8'd0);
      tick();
    end
    chk("to_c18", 1, 1, 0, 0, 4'b0000, 1, 0, 8'd0);
    tick();
    chk("to_c19", 1, 1, 0, 0, 4'b0000, 1, 0, 8'd0);
    drv(1, 0, 4'b0010, 4'h0, 0, 0); tick();
    chk("to_c20", 0, 1, 0, 0, 4'b0000, 1, 0, 8'd0);
    drv(0, 0, 4'h0, 4'h0, 0, 0);

    // long block: stall saturation, then reset mid-run
    do_reset();
    chk("st_c0", 1, 1, 0, 0, 4'h0, 0, 0, 8'd0);
    drv(1, 0, 4'b0101, 4'h0, 0, 0); tick();
    chk("st_c1", 0, 1, 0, 0, 4'h0, 0, 0, 8'd0);
    drv(0, 0, 4'h0, 4'h0, 0, 0); tick();
    chk("st_c2", 0, 1, 1, 0, 4'b0101, 0, 0, 8'd0);
    drv(0, 1, 4'h0, 4'b0001, 1, 0); tick();
    chk("st_c3", 0, 0, 0, 0, 4'b0101, 0, 0, 8'd0);
    drv(0, 0, 4'h0, 4'h0, 1, 0); tick();
    for (int n = 1; n <= 300; n++) begin
      chk($sformatf("st_n%0d", n), 0, 0, 0, 0, 4'b0101,
          0, 0, (n > 255) ? 8'd255 : 8'(n));
      if (n < 300) begin
        drv(0, 0, 4'h0, 4'h0, 1, 0);
        tick();
      end
    end
    rst = 1'b1;
    drv(0, 0, 4'h0, 4'h0, 1, 0); tick();
    rst = 1'b0;
    chk("rst_c1", 1, 1, 0, 0, 4'h0, 0, 0, 8'd0);
    drv(0, 0, 4'h0, 4'h0, 1, 1); tick();
    chk("rst_c2", 1, 1, 0, 0, 4'h0, 0, 0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ntt_dispatch_arbiter.md
NTT_DISPATCH_ARBITER -- requirements
Module: ntt_dispatch_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req_valid_0 / req_valid_1  input  1  job request from core 0 / core 1 sequencer.
REQ-005 req_ready_0 / req_ready_1  output  1  slot free; a request is accepted on a cycle with valid and ready both high.
REQ-006 req_bank_mask_0 / req_bank_mask_1  input  4  banks the job touches; bit i = bank i; sampled on accept.
REQ-007 busy_0 / busy_1  input  1  core running status from each NTT core.
REQ-008 start_0 / start_1  output  1  registered one-cycle start pulse to each core.
REQ-009 owned_mask  output  4  registered OR of the bank masks currently held by launched jobs.
REQ-010 stall_cnt  output  8  saturating count of cycles in which at least one PEND slot was not granted.
REQ-011 timeout_err_0 / timeout_err_1  output  1  sticky flag: core never raised busy after start.

Function
REQ-012 Each core slot SHALL run an FSM with states IDLE, PEND, WAIT_BUSY, RUN.
REQ-013 req_ready_x SHALL be 1 only in IDLE; an accept moves the slot to PEND and latches the mask.
REQ-014 A PEND slot SHALL be eligible when (latched mask & owned_mask) == 0; a mask of 0 is always eligible and claims no banks.
REQ-015 Both eligible with disjoint masks: SHALL grant both in the same cycle.
REQ-016 Both eligible with overlapping masks: SHALL grant only the core selected by rr_ptr; rr_ptr then SHALL flip to the other core.
REQ-017 An uncontended grant SHALL NOT change rr_ptr.
REQ-018 Grant in cycle N: slot enters WAIT_BUSY, owned_mask gains the mask, and start_x = 1 during cycle N+1 only.
REQ-019 Minimum latency SHALL be: accept in cycle 0, PEND in cycle 1, start in cycle 2.
REQ-020 WAIT_BUSY: busy_x = 1 moves the slot to RUN.
REQ-021 WAIT_BUSY timeout: if busy_x is not seen within 16 cycles of entering WAIT_BUSY, the slot SHALL set timeout_err_x, release its banks and return to IDLE.
REQ-022 RUN: busy_x = 0 SHALL release the slot's banks and return it to IDLE at that edge.
REQ-023 Released banks SHALL be grantable from the next cycle; there is no same-cycle release-to-grant bypass.
REQ-024 A new request SHALL be accepted the cycle after return to IDLE.
REQ-025 stall_cnt SHALL increment when any slot is in PEND and is not granted that cycle, and SHALL saturate at 255.
REQ-026 busy_x while the slot is IDLE or PEND SHALL be ignored.

Reset
REQ-027 rst SHALL override all activity, including mid-job.
REQ-028 On rst: slots to IDLE, owned_mask = 0, start_x = 0, rr_ptr = 0 (core 0 first), stall_cnt = 0, timeout_err_x = 0.
REQ-029 req_ready_x SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 Package ntt_sched_pkg SHALL hold:
- slot state enum
- NUM_BANKS = 4
- START_TIMEOUT = 16
- STALL_W = 8
REQ-031 Per-core FSM, timeout counter and mask latch SHALL be sub-module ntt_core_slot, instantiated twice.
REQ-032 Arbitration, rr_ptr, owned_mask and stall_cnt SHALL live in the top module.

Verification
REQ-033 Core 0 mask 0011, core 1 mask 1100, both accepted in cycle 0 -> start_0 and start_1 both high in cycle 2, owned_mask = 1111.
REQ-034 Both masks 0001, accepted together -> start_0 in cycle 2; start_1 only in the cycle after busy_0 falls; next same-mask collision grants core 1 first.
REQ-035 Core 0 granted mask 0001, busy_0 never asserts -> at WAIT_BUSY cycle 16: timeout_err_0 = 1, owned_mask = 0, req_ready_0 = 1.
REQ-036 rst asserted during RUN with owned_mask = 0101 -> next cycle: owned_mask = 0, start = 0, both req_ready = 1, stall_cnt = 0.
REQ-037 Core 1 PEND blocked by a core 0 job for 300 cycles -> stall_cnt reaches 255 and holds.
REQ-038 Mask 0000 request while owned_mask = 1111 -> start issued two cycles after accept, owned_mask unchanged.
